// File: rtl/pic_command_word_sequencer_pkg.sv
// 8259A command word sequencer: shared state enum and field bit indices.
// Used by the sequencer top and its OCW decoder.
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } sequencer_state_t;

  localparam int unsigned ICW1_LTIM = 3;
  localparam int unsigned ICW1_SNGL = 1;
  localparam int unsigned ICW1_IC4  = 0;

  localparam int unsigned ICW4_SFNM = 4;
  localparam int unsigned ICW4_BUF  = 3;
  localparam int unsigned ICW4_MS   = 2;
  localparam int unsigned ICW4_AEOI = 1;
  localparam int unsigned ICW4_UPM  = 0;

  localparam int unsigned OCW2_R   = 7;
  localparam int unsigned OCW2_SL  = 6;
  localparam int unsigned OCW2_EOI = 5;

  localparam int unsigned OCW3_ESMM = 6;
  localparam int unsigned OCW3_SMM  = 5;
  localparam int unsigned OCW3_P    = 2;
  localparam int unsigned OCW3_RR   = 1;
  localparam int unsigned OCW3_RIS  = 0;

endpackage

// File: rtl/pic_command_word_sequencer_if.sv
// Command word sequencer bus: write strobes and data in,
// configuration registers and command pulses out.
interface pic_command_word_sequencer_if;
  logic [7:0] internal_data_bus;
  logic       write_initial_command_word_1;
  logic       write_initial_command_word_2_4;
  logic       write_operation_control_word_1;
  logic       write_operation_control_word_2;
  logic       write_operation_control_word_3;

  logic       init_done;
  logic       level_or_edge_n;
  logic       single_mode;
  logic [4:0] vector_base;
  logic [7:0] cascade_config;
  logic       auto_eoi;
  logic       special_fully_nested;
  logic       buffered_mode;
  logic       buffered_master;
  logic       mode_8086;
  logic [7:0] interrupt_mask;
  logic       eoi_pulse;
  logic       specific_eoi_pulse;
  logic       set_priority_pulse;
  logic       rotate_on_eoi;
  logic       auto_rotate;
  logic [2:0] ocw2_level;
  logic       read_isr_select;
  logic       poll_pulse;
  logic       special_mask_mode;

  modport master (
    output internal_data_bus,
    output write_initial_command_word_1,
    output write_initial_command_word_2_4,
    output write_operation_control_word_1,
    output write_operation_control_word_2,
    output write_operation_control_word_3,
    input  init_done, level_or_edge_n, single_mode,
    input  vector_base, cascade_config,
    input  auto_eoi, special_fully_nested,
    input  buffered_mode, buffered_master, mode_8086,
    input  interrupt_mask,
    input  eoi_pulse, specific_eoi_pulse,
    input  set_priority_pulse, rotate_on_eoi,
    input  auto_rotate, ocw2_level,
    input  read_isr_select, poll_pulse,
    input  special_mask_mode
  );

  modport slave (
    input  internal_data_bus,
    input  write_initial_command_word_1,
    input  write_initial_command_word_2_4,
    input  write_operation_control_word_1,
    input  write_operation_control_word_2,
    input  write_operation_control_word_3,
    output init_done, level_or_edge_n, single_mode,
    output vector_base, cascade_config,
    output auto_eoi, special_fully_nested,
    output buffered_mode, buffered_master, mode_8086,
    output interrupt_mask,
    output eoi_pulse, specific_eoi_pulse,
    output set_priority_pulse, rotate_on_eoi,
    output auto_rotate, ocw2_level,
    output read_isr_select, poll_pulse,
    output special_mask_mode
  );
endinterface

// File: rtl/pic_command_word_sequencer_ocw_decoder.sv
// OCW2/OCW3 field decode into command pulses and register enables.
// SMM outputs exist only with SPECIAL_MASK_MODE_EN.
module pic_ocw_decoder
  import pic_pkg::*;
(
  input  logic [7:0] data,
  input  logic       ocw2_en,
  input  logic       ocw3_en,
  output logic       eoi,
  output logic       specific_eoi,
  output logic       set_priority,
  output logic       rotate,
  output logic       auto_rotate_set,
  output logic       auto_rotate_clr,
  output logic       poll,
  output logic       isr_load,
  output logic       isr_value
`ifdef SPECIAL_MASK_MODE_EN
  ,
  output logic       smm_load,
  output logic       smm_value
`endif
);

  logic [2:0] cmd;
  logic       unused_bits;

  assign cmd = {data[OCW2_R], data[OCW2_SL], data[OCW2_EOI]};
  assign unused_bits = ^data[4:3];

  always_comb begin
    eoi             = 1'b0;
    specific_eoi    = 1'b0;
    set_priority    = 1'b0;
    rotate          = 1'b0;
    auto_rotate_set = 1'b0;
    auto_rotate_clr = 1'b0;
    if (ocw2_en) begin
      unique case (cmd)
        3'b001: eoi = 1'b1;
        3'b011: specific_eoi = 1'b1;
        3'b101: begin
          eoi    = 1'b1;
          rotate = 1'b1;
        end
        3'b111: begin
          specific_eoi = 1'b1;
          rotate       = 1'b1;
        end
        3'b100: auto_rotate_set = 1'b1;
        3'b000: auto_rotate_clr = 1'b1;
        3'b110: set_priority = 1'b1;
        default: ;
      endcase
    end
  end

  // Poll takes precedence over a register-read select in the same byte
  always_comb begin
    poll      = 1'b0;
    isr_load  = 1'b0;
    isr_value = data[OCW3_RIS];
    if (ocw3_en) begin
      unique case (1'b1)
        data[OCW3_P]:  poll = 1'b1;
        data[OCW3_RR]: isr_load = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SPECIAL_MASK_MODE_EN
  assign smm_load  = ocw3_en & data[OCW3_ESMM];
  assign smm_value = data[OCW3_SMM];
`endif

endmodule

// File: rtl/pic_command_word_sequencer.sv
// 8259A ICW/OCW sequencer and configuration register file.
// Define SPECIAL_MASK_MODE_EN to build the OCW3 special mask mode flop.
module pic_command_word_sequencer
  import pic_pkg::*;
#(
  parameter int IRQ_COUNT = 8,
  parameter logic [IRQ_COUNT-1:0] MASK_RESET = '0
) (
  input logic clock,
  input logic reset,
  pic_command_word_sequencer_if.slave bus
);

  sequencer_state_t state;
  logic             ic4_q;
  logic             icw1;
  logic             ocw2_en;
  logic             ocw3_en;
  logic [7:0]       data;

  logic dec_eoi;
  logic dec_seoi;
  logic dec_setp;
  logic dec_rot;
  logic dec_ar_set;
  logic dec_ar_clr;
  logic dec_poll;
  logic dec_isr_load;
  logic dec_isr_value;

  assign data    = bus.internal_data_bus;
  assign icw1    = bus.write_initial_command_word_1;
  assign ocw2_en = bus.write_operation_control_word_2
                 & (state == READY) & ~icw1;
  assign ocw3_en = bus.write_operation_control_word_3
                 & (state == READY) & ~icw1;

  assign bus.init_done = (state == READY);

`ifdef SPECIAL_MASK_MODE_EN
  logic dec_smm_load;
  logic dec_smm_value;
`endif

  pic_ocw_decoder u_dec (
    .data            (data),
    .ocw2_en         (ocw2_en),
    .ocw3_en         (ocw3_en),
    .eoi             (dec_eoi),
    .specific_eoi    (dec_seoi),
    .set_priority    (dec_setp),
    .rotate          (dec_rot),
    .auto_rotate_set (dec_ar_set),
    .auto_rotate_clr (dec_ar_clr),
    .poll            (dec_poll),
    .isr_load        (dec_isr_load),
    .isr_value       (dec_isr_value)
`ifdef SPECIAL_MASK_MODE_EN
    ,
    .smm_load        (dec_smm_load),
    .smm_value       (dec_smm_value)
`endif
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state                    <= UNINIT;
      ic4_q                    <= 1'b0;
      bus.level_or_edge_n      <= 1'b0;
      bus.single_mode          <= 1'b0;
      bus.vector_base          <= '0;
      bus.cascade_config       <= '0;
      bus.auto_eoi             <= 1'b0;
      bus.special_fully_nested <= 1'b0;
      bus.buffered_mode        <= 1'b0;
      bus.buffered_master      <= 1'b0;
      bus.mode_8086            <= 1'b0;
      bus.interrupt_mask       <= MASK_RESET;
      bus.eoi_pulse            <= 1'b0;
      bus.specific_eoi_pulse   <= 1'b0;
      bus.set_priority_pulse   <= 1'b0;
      bus.rotate_on_eoi        <= 1'b0;
      bus.auto_rotate          <= 1'b0;
      bus.ocw2_level           <= '0;
      bus.read_isr_select      <= 1'b0;
      bus.poll_pulse           <= 1'b0;
    end else begin
      bus.eoi_pulse          <= dec_eoi;
      bus.specific_eoi_pulse <= dec_seoi;
      bus.set_priority_pulse <= dec_setp;
      bus.rotate_on_eoi      <= dec_rot;
      bus.poll_pulse         <= dec_poll;
      if (icw1) begin
        state                    <= WAIT_ICW2;
        ic4_q                    <= data[ICW1_IC4];
        bus.level_or_edge_n      <= data[ICW1_LTIM];
        bus.single_mode          <= data[ICW1_SNGL];
        bus.interrupt_mask       <= MASK_RESET;
        bus.auto_eoi             <= 1'b0;
        bus.special_fully_nested <= 1'b0;
        bus.buffered_mode        <= 1'b0;
        bus.buffered_master      <= 1'b0;
        bus.mode_8086            <= 1'b0;
        bus.auto_rotate          <= 1'b0;
        bus.read_isr_select      <= 1'b0;
      end else begin
        unique case (state)
          WAIT_ICW2: if (bus.write_initial_command_word_2_4) begin
            bus.vector_base <= data[7:3];
            state <= !bus.single_mode ? WAIT_ICW3
                   : ic4_q            ? WAIT_ICW4
                   :                    READY;
          end
          WAIT_ICW3: if (bus.write_initial_command_word_2_4) begin
            bus.cascade_config <= data;
            state <= ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (bus.write_initial_command_word_2_4) begin
            bus.special_fully_nested <= data[ICW4_SFNM];
            bus.buffered_mode        <= data[ICW4_BUF];
            bus.buffered_master      <= data[ICW4_MS];
            bus.auto_eoi             <= data[ICW4_AEOI];
            bus.mode_8086            <= data[ICW4_UPM];
            state                    <= READY;
          end
          READY: begin
            if (bus.write_operation_control_word_1)
              bus.interrupt_mask <= data;
            if (ocw2_en)
              bus.ocw2_level <= data[2:0];
            if (dec_ar_set)
              bus.auto_rotate <= 1'b1;
            else if (dec_ar_clr)
              bus.auto_rotate <= 1'b0;
            if (dec_isr_load)
              bus.read_isr_select <= dec_isr_value;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPECIAL_MASK_MODE_EN
  always_ff @(posedge clock) begin
    if (reset || icw1)
      bus.special_mask_mode <= 1'b0;
    else if (dec_smm_load)
      bus.special_mask_mode <= dec_smm_value;
  end
`else
  assign bus.special_mask_mode = 1'b0;
`endif

endmodule

// File: tb/tb_pic_command_word_sequencer.sv
// Directed bench for pic_command_word_sequencer with a queue-based model.
// Honours SPECIAL_MASK_MODE_EN the same way the design does.
module tb_pic_command_word_sequencer;

  localparam logic [7:0] MRST = 8'h00;
  localparam logic [3:0] S_ICW1 = 4'b0001;
  localparam logic [3:0] S_A0   = 4'b0010;
  localparam logic [3:0] S_OCW2 = 4'b0100;
  localparam logic [3:0] S_OCW3 = 4'b1000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  bit   chk_en = 1'b0;

  pic_command_word_sequencer_if bus ();

  pic_command_word_sequencer #(
    .IRQ_COUNT  (8),
    .MASK_RESET (MRST)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model: remaining ICW roles held in a queue
  int         m_todo[$];
  bit         m_ready;
  logic       m_ltim, m_sngl;
  logic [4:0] m_vec;
  logic [7:0] m_cas, m_mask;
  logic       m_aeoi, m_sfnm, m_buf, m_bm, m_upm;
  logic       m_eoi, m_seoi, m_setp, m_rot, m_ar, m_poll;
  logic [2:0] m_lvl;
  logic       m_ris, m_smm;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic model_reset();
    m_todo.delete();
    m_ready = 0; m_ltim = 0; m_sngl = 0; m_vec = '0; m_cas = '0;
    m_mask = MRST; m_aeoi = 0; m_sfnm = 0; m_buf = 0; m_bm = 0;
    m_upm = 0; m_eoi = 0; m_seoi = 0; m_setp = 0; m_rot = 0;
    m_ar = 0; m_poll = 0; m_lvl = '0; m_ris = 0; m_smm = 0;
  endtask

  task automatic model_apply(input logic [3:0] stb, input logic [7:0] d);
    bit was_ready;
    int role;
    m_eoi = 0; m_seoi = 0; m_setp = 0; m_rot = 0; m_poll = 0;
    if (stb[0]) begin
      m_ltim = d[3]; m_sngl = d[1];
      m_todo.delete();
      m_todo.push_back(2);
      if (!d[1]) m_todo.push_back(3);
      if (d[0]) m_todo.push_back(4);
      m_ready = 0; m_mask = MRST; m_smm = 0; m_ris = 0; m_ar = 0;
      m_aeoi = 0; m_sfnm = 0; m_buf = 0; m_bm = 0; m_upm = 0;
    end else begin
      was_ready = m_ready;
      if (stb[1]) begin
        if (m_todo.size() > 0) begin
          role = m_todo.pop_front();
          if (role == 2) m_vec = d[7:3];
          else if (role == 3) m_cas = d;
          else begin
            m_sfnm = d[4]; m_buf = d[3]; m_bm = d[2];
            m_aeoi = d[1]; m_upm = d[0];
          end
          if (m_todo.size() == 0) m_ready = 1;
        end else if (was_ready) m_mask = d;
      end
      if (stb[2] && was_ready) begin
        m_lvl = d[2:0];
        if (d[5]) begin
          if (d[6]) m_seoi = 1; else m_eoi = 1;
          m_rot = d[7];
        end else if (d[7] && d[6]) m_setp = 1;
        else if (d[7]) m_ar = 1;
        else if (!d[6]) m_ar = 0;
      end
      if (stb[3] && was_ready) begin
        if (d[2]) m_poll = 1;
        else if (d[1]) m_ris = d[0];
`ifdef SPECIAL_MASK_MODE_EN
        if (d[6]) m_smm = d[5];
`endif
      end
    end
  endtask

  task automatic step(input logic [3:0] stb, input logic [7:0] d);
    bus.internal_data_bus = d;
    bus.write_initial_command_word_1   = stb[0];
    bus.write_initial_command_word_2_4 = stb[1];
    bus.write_operation_control_word_1 = stb[1];
    bus.write_operation_control_word_2 = stb[2];
    bus.write_operation_control_word_3 = stb[3];
    @(posedge clock);
    model_apply(stb, d);
    #1;
    bus.internal_data_bus = '0;
    bus.write_initial_command_word_1   = 0;
    bus.write_initial_command_word_2_4 = 0;
    bus.write_operation_control_word_1 = 0;
    bus.write_operation_control_word_2 = 0;
    bus.write_operation_control_word_3 = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clock);
    model_reset();
    #1 reset = 0;
  endtask

  always @(negedge clock) if (chk_en) begin
    chk("init_done",  bus.init_done, m_ready);
    chk("ltim",       bus.level_or_edge_n, m_ltim);
    chk("sngl",       bus.single_mode, m_sngl);
    chk("vector",     bus.vector_base, m_vec);
    chk("cascade",    bus.cascade_config, m_cas);
    chk("aeoi",       bus.auto_eoi, m_aeoi);
    chk("sfnm",       bus.special_fully_nested, m_sfnm);
    chk("buf",        bus.buffered_mode, m_buf);
    chk("bufmaster",  bus.buffered_master, m_bm);
    chk("upm",        bus.mode_8086, m_upm);
    chk("mask",       bus.interrupt_mask, m_mask);
    chk("eoi",        bus.eoi_pulse, m_eoi);
    chk("seoi",       bus.specific_eoi_pulse, m_seoi);
    chk("setprio",    bus.set_priority_pulse, m_setp);
    chk("rot_eoi",    bus.rotate_on_eoi, m_rot);
    chk("autorot",    bus.auto_rotate, m_ar);
    chk("level",      bus.ocw2_level, m_lvl);
    chk("ris",        bus.read_isr_select, m_ris);
    chk("poll",       bus.poll_pulse, m_poll);
    chk("smm",        bus.special_mask_mode, m_smm);
  end

  initial begin
    bus.internal_data_bus = '0;
    bus.write_initial_command_word_1   = 0;
    bus.write_initial_command_word_2_4 = 0;
    bus.write_operation_control_word_1 = 0;
    bus.write_operation_control_word_2 = 0;
    bus.write_operation_control_word_3 = 0;
    do_reset();
    chk_en = 1;
    chk("rst_mask", bus.interrupt_mask, 8'h00);
    chk("rst_done", bus.init_done, 1'b0);

    // UNINIT ignores A0 and OCW writes
    step(S_A0, 8'hAA);
    step(S_OCW2, 8'h20);
    step(S_OCW3, 8'h0B);
    chk("uninit_mask", bus.interrupt_mask, 8'h00);

    // Full cascade init with ICW4
    step(S_ICW1, 8'h11);
    step(S_A0, 8'h48);
    step(S_A0, 8'h04);
    chk("mid_done", bus.init_done, 1'b0);
    step(S_A0, 8'h03);
    chk("full_vec", bus.vector_base, 8'h09);
    chk("full_cas", bus.cascade_config, 8'h04);
    chk("full_aeoi", bus.auto_eoi, 1'b1);
    chk("full_upm", bus.mode_8086, 1'b1);
    chk("full_done", bus.init_done, 1'b1);
    step(S_A0, 8'h5A);
    chk("ocw1_mask", bus.interrupt_mask, 8'h5A);

    // OCW2 commands
    step(S_OCW2, 8'h63);
    chk("seoi_hi", bus.specific_eoi_pulse, 1'b1);
    chk("seoi_lvl", bus.ocw2_level, 8'h03);
    step(4'b0000, 8'h00);
    chk("seoi_lo", bus.specific_eoi_pulse, 1'b0);
    step(S_OCW2, 8'h20);
    chk("eoi_hi", bus.eoi_pulse, 1'b1);
    step(S_OCW2, 8'h80);
    chk("ar_set", bus.auto_rotate, 1'b1);
    step(S_OCW2, 8'hE5);
    step(S_OCW2, 8'hA0);
    step(S_OCW2, 8'hC6);
    step(S_OCW2, 8'h47);
    step(S_OCW2, 8'h00);
    chk("ar_clr", bus.auto_rotate, 1'b0);

    // OCW3 commands
    step(S_OCW3, 8'h0B);
    chk("ris_set", bus.read_isr_select, 1'b1);
    step(S_OCW3, 8'h0C);
    chk("poll_hi", bus.poll_pulse, 1'b1);
    chk("ris_keep", bus.read_isr_select, 1'b1);
    step(S_OCW3, 8'h68);
`ifdef SPECIAL_MASK_MODE_EN
    chk("smm_on", bus.special_mask_mode, 1'b1);
`else
    chk("smm_off", bus.special_mask_mode, 1'b0);
`endif
    step(S_OCW3, 8'h0A);
    step(S_OCW3, 8'h4B);

    // Re-init from READY, single with ICW4
    step(S_ICW1, 8'h13);
    chk("reinit_done", bus.init_done, 1'b0);
    chk("reinit_mask", bus.interrupt_mask, 8'h00);
    chk("reinit_ris", bus.read_isr_select, 1'b0);
    step(S_OCW2, 8'h20);
    step(S_A0, 8'h08);
    step(S_A0, 8'h1E);
    chk("icw4_sfnm", bus.special_fully_nested, 1'b1);
    chk("icw4_bm", bus.buffered_master, 1'b1);

    // Short init: single, no ICW4
    step(S_ICW1, 8'h12);
    step(S_A0, 8'h20);
    chk("short_done", bus.init_done, 1'b1);
    chk("short_mask", bus.interrupt_mask, 8'h00);
    step(S_A0, 8'hF0);
    chk("short_ocw1", bus.interrupt_mask, 8'hF0);

    // ICW1 while waiting for ICW3 restarts the flow
    step(S_ICW1, 8'h10);
    step(S_A0, 8'h30);
    step(S_ICW1, 8'h19);
    chk("restart_ltim", bus.level_or_edge_n, 1'b1);
    step(S_A0, 8'h48);
    step(S_A0, 8'h80);
    step(S_A0, 8'h01);
    chk("restart_done", bus.init_done, 1'b1);

    // ICW1 wins over coincident strobes
    step(S_ICW1 | S_A0 | S_OCW2 | S_OCW3, 8'h2C);
    chk("prio_eoi", bus.eoi_pulse, 1'b0);
    chk("prio_done", bus.init_done, 1'b0);

    // Reset while waiting for ICW4
    step(S_ICW1, 8'h13);
    step(S_A0, 8'hF8);
    do_reset();
    chk("rst4_done", bus.init_done, 1'b0);
    chk("rst4_vec", bus.vector_base, 8'h00);
    step(S_A0, 8'h55);
    chk("rst4_ign", bus.interrupt_mask, 8'h00);
    step(4'b0000, 8'h00);

    @(negedge clock);
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
